// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: FSM encoding, default
// geometry and the access-legality check.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_DEPTH_WORDS = 256;
    localparam int unsigned DEFAULT_LATENCY     = 2;

    // Misaligned or beyond the backing store; such accesses never touch storage.
    function automatic logic addr_error(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Byte-enabled word storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module data_mem_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    be,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency memory responder: accepts one request, waits LATENCY cycles,
// then answers for one cycle and commits stores on that same edge.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned LATENCY     = DEFAULT_LATENCY
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t        state, state_next;
    logic [3:0]    cnt, cnt_next;
    logic          write_q, err_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          accept, rsp_live, mem_we;
    logic [31:0]   mem_rdata;

    assign accept = req_valid && req_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                write_q <= req_write;
                err_q   <= addr_error(req_addr, DEPTH_WORDS);
                idx_q   <= req_addr[AW+1:2];
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Gating with reset aborts a response (and its store) caught by reset in RESP.
    assign rsp_live  = (state == RESP) && !reset;
    assign mem_we    = rsp_live && write_q && !err_q;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = rsp_live;
    assign rsp_error = rsp_live && err_q;
    assign rsp_rdata = (rsp_live && !err_q && !write_q) ? mem_rdata : 32'h0;

    data_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clock (clock),
        .we    (mem_we),
        .addr  (idx_q),
        .wdata (wdata_q),
        .be    (be_q),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: table of single requests on the
// default build, plus hand sequences for back-to-back, reset abort and LATENCY=1.
module tb_data_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, rsp_valid, rsp_error, busy;
    logic [31:0] rsp_rdata;

    logic        v1, w1;
    logic [31:0] a1, d1;
    logic [3:0]  b1;
    logic        rdy1, rv1, re1, busy1;
    logic [31:0] rd1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    data_mem_responder u_dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .busy(busy)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_lat1 (
        .clock(clock), .reset(reset), .req_valid(v1), .req_ready(rdy1),
        .req_write(w1), .req_addr(a1), .req_wdata(d1), .req_be(b1),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_error(re1), .busy(busy1)
    );

    typedef struct {
        string       name;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request on the LATENCY=2 DUT; checks latency, error and data.
    task automatic do_req(input vec_t v);
        int n;
        @(negedge clock);
        req_valid = 1'b1; req_write = v.write; req_addr = v.addr;
        req_wdata = v.wdata; req_be = v.be;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            chk({v.name, " accept timeout"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk({v.name, " latency"}, 32'(n), 32'd2);
        chk({v.name, " error"}, 32'(rsp_error), 32'(v.exp_err));
        chk({v.name, " rdata"}, rsp_rdata, v.exp_rdata);
    endtask

    vec_t vecs[$];

    initial begin
        int acc[3];
        int na, cyc, nrsp;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0;
        v1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0; b1 = '0;
        repeat (3) @(negedge clock);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_error", 32'(rsp_error), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        chk("ready after reset", 32'(req_ready), 32'd1);

        vecs = '{
            '{"st 10 full",     1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 1'b0, 32'h0},
            '{"ld 10",          1'b0, 32'h10,  32'h0,        4'h0, 1'b0, 32'hDEADBEEF},
            '{"st 10 be0101",   1'b1, 32'h10,  32'h11223344, 4'h5, 1'b0, 32'h0},
            '{"ld 10 merged",   1'b0, 32'h10,  32'hFFFFFFFF, 4'hF, 1'b0, 32'hDE22BE44},
            '{"ld 13 misalign", 1'b0, 32'h13,  32'h0,        4'h0, 1'b1, 32'h0},
            '{"st 0",           1'b1, 32'h0,   32'hCAFEF00D, 4'hF, 1'b0, 32'h0},
            '{"st 400 oor",     1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0},
            '{"ld 0 kept",      1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'hCAFEF00D},
            '{"st 14",          1'b1, 32'h14,  32'hAABBCCDD, 4'hF, 1'b0, 32'h0},
            '{"st 14 be0",      1'b1, 32'h14,  32'h12345678, 4'h0, 1'b0, 32'h0},
            '{"ld 14 noop",     1'b0, 32'h14,  32'h0,        4'h0, 1'b0, 32'hAABBCCDD},
            '{"st 3fc last",    1'b1, 32'h3FC, 32'h0BADCAFE, 4'hF, 1'b0, 32'h0},
            '{"st 3fe misalign",1'b1, 32'h3FE, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0},
            '{"ld 3fc",         1'b0, 32'h3FC, 32'h0,        4'h0, 1'b0, 32'h0BADCAFE},
            '{"ld 400 oor",     1'b0, 32'h400, 32'h0,        4'h0, 1'b1, 32'h0},
            '{"st 20 old",      1'b1, 32'h20,  32'h55555555, 4'hF, 1'b0, 32'h0}
        };
        foreach (vecs[i]) do_req(vecs[i]);

        // Back-to-back loads with req_valid held high.
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_be = 4'h0;
        na = 0; cyc = 0; nrsp = 0;
        while (na < 3 && cyc < 30) begin
            if (req_ready) begin
                acc[na] = cyc;
                na++;
            end
            if (rsp_valid) begin
                nrsp++;
                chk("b2b rdata", rsp_rdata, 32'hDE22BE44);
            end
            @(negedge clock);
            cyc++;
        end
        req_valid = 1'b0;
        chk("b2b accept count", 32'(na), 32'd3);
        if (na == 3) begin
            chk("b2b gap 1", 32'(acc[1] - acc[0]), 32'd3);
            chk("b2b gap 2", 32'(acc[2] - acc[1]), 32'd3);
        end
        chk("b2b ready low after accept", 32'(req_ready), 32'd0);
        repeat (3) begin
            if (rsp_valid) nrsp++;
            @(negedge clock);
        end
        chk("b2b responses", 32'(nrsp), 32'd3);

        // Reset in WAIT aborts the store.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
        req_wdata = 32'hAAAAAAAA; req_be = 4'hF;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        chk("abort in wait busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        nrsp = 0;
        repeat (4) begin
            if (rsp_valid) nrsp++;
            @(negedge clock);
        end
        chk("abort wait no rsp", 32'(nrsp), 32'd0);
        chk("abort wait ready", 32'(req_ready), 32'd1);
        do_req('{"ld 20 after wait abort", 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h55555555});

        // Reset in RESP also suppresses the response and the commit.
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
        req_wdata = 32'h99999999; req_be = 4'hF;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        chk("abort resp busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort resp rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("abort resp ready", 32'(req_ready), 32'd1);
        do_req('{"ld 20 after resp abort", 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h55555555});

        // LATENCY=1 build: response one edge after accept, next accept two edges after.
        @(negedge clock);
        v1 = 1'b1; w1 = 1'b1; a1 = 32'h8; d1 = 32'h13579BDF; b1 = 4'hF;
        chk("lat1 ready", 32'(rdy1), 32'd1);
        @(negedge clock);
        chk("lat1 store rsp_valid", 32'(rv1), 32'd1);
        chk("lat1 store error", 32'(re1), 32'd0);
        chk("lat1 ready in resp", 32'(rdy1), 32'd0);
        w1 = 1'b0;
        @(negedge clock);
        chk("lat1 idle rsp_valid", 32'(rv1), 32'd0);
        chk("lat1 re-accept ready", 32'(rdy1), 32'd1);
        @(negedge clock);
        v1 = 1'b0;
        chk("lat1 load rsp_valid", 32'(rv1), 32'd1);
        chk("lat1 load rdata", rd1, 32'h13579BDF);
        @(negedge clock);
        chk("lat1 done", 32'(busy1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
